// File: rtl/sync_operand_injector.sv
// sync_operand_injector
// Clocked entry stage of the square-root unit. Unpacks an IEEE-754 single
// operand, reports special cases on a clocked side channel, and injects
// normal/subnormal operands into the asynchronous normalization loop as a
// registered dual-rail four-phase (return-to-zero) codeword.
// Optional feature: define ACK_TIMEOUT_EN to compile in the sticky
// acknowledge-timeout detector; without it timeout_err is tied low.
module sync_operand_injector #(
  parameter int EW        = 8,
  parameter int RW        = 23,
  parameter int TO_CYCLES = 1023
) (
  input  logic                      clk,
  input  logic                      arst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [EW+RW:0]            in_data,
  output logic                      special_valid,
  output logic [1:0]                special_kind,
  output logic [2*(EW+RW+2)-1:0]    data_o,
  input  logic                      ack_o,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int NB = EW + RW + 2;

  typedef enum logic [1:0] {IDLE, DATA, SPACER} state_t;

  state_t          state;
  logic            ack_m;
  logic            ack_s;

  logic            sign;
  logic [EW-1:0]   exp_f;
  logic [RW-1:0]   frac_f;
  logic            is_zero;
  logic            is_nan;
  logic            is_inf;
  logic            is_neg;
  logic            is_special;
  logic [1:0]      kind_c;
  logic [NB-1:0]   plain;
  logic [2*NB-1:0] codeword;
  logic            accept;
  logic            load_data;
  logic            load_spacer;

  assign sign   = in_data[EW+RW];
  assign exp_f  = in_data[EW+RW-1:RW];
  assign frac_f = in_data[RW-1:0];

  // The acknowledge comes from an unclocked stage, so it is brought in through two flops
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      ack_m <= 1'b0;
      ack_s <= 1'b0;
    end else begin
      ack_m <= ack_o;
      ack_s <= ack_m;
    end
  end

  // Classify the operand; -0 counts as zero and a negative NaN stays a NaN
  always_comb begin
    is_zero    = (exp_f == '0) && (frac_f == '0);
    is_nan     = (&exp_f) && (frac_f != '0);
    is_inf     = (&exp_f) && (frac_f == '0) && !sign;
    is_neg     = sign && !is_zero && !is_nan;
    is_special = is_zero || is_nan || is_inf || is_neg;
    kind_c     = 2'b00;
    if (is_nan)
      kind_c = 2'b10;
    else if (is_neg)
      kind_c = 2'b11;
    else if (is_inf)
      kind_c = 2'b01;
  end

  // Build the single-rail value; subnormals get exponent 1 and no hidden bit,
  // leaving their leading zeros for the normalize loop to strip
  always_comb begin
    if (exp_f == '0)
      plain = {{EW{1'b0}}, 1'b1, 1'b0, frac_f};
    else
      plain = {1'b0, exp_f, 1'b1, frac_f};
  end

  // Expand to dual rail: wire 2k+1 carries a one, wire 2k carries a zero
  always_comb begin
    codeword = '0;
    for (int k = 0; k < NB; k++) begin
      codeword[2*k+1] = plain[k];
      codeword[2*k]   = ~plain[k];
    end
  end

  assign in_ready    = (state == IDLE) && !ack_s && arst;
  assign accept      = in_valid && in_ready;
  assign load_data   = accept && !is_special;
  assign load_spacer = (state == DATA) && ack_s;

  // Four-phase sequencer; every output it drives is a flop so data_o never glitches
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state         <= IDLE;
      data_o        <= '0;
      special_valid <= 1'b0;
      special_kind  <= 2'b00;
      busy          <= 1'b0;
    end else begin
      special_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_special) begin
              special_valid <= 1'b1;
              special_kind  <= kind_c;
            end else begin
              data_o <= codeword;
              state  <= DATA;
              busy   <= 1'b1;
            end
          end
        end
        DATA: begin
          if (ack_s) begin
            data_o <= '0;
            state  <= SPACER;
          end
        end
        SPACER: begin
          if (!ack_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          data_o <= '0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

`ifdef ACK_TIMEOUT_EN
  localparam int CW = $clog2(TO_CYCLES + 1);
  localparam logic [CW-1:0] TO_LIM    = CW'(TO_CYCLES);
  localparam logic [CW-1:0] TO_LIM_M1 = CW'(TO_CYCLES - 1);

  logic [CW-1:0] to_cnt;

  // Count cycles spent waiting in each handshake phase; the flag is sticky and never stalls the FSM
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else if (load_data || load_spacer) begin
      to_cnt <= '0;
    end else if ((state != IDLE) && (to_cnt != TO_LIM)) begin
      to_cnt <= to_cnt + 1'b1;
      if (to_cnt == TO_LIM_M1)
        timeout_err <= 1'b1;
    end
  end
`else
  // No detector in this build; TO_CYCLES is a signed int so this is constant low
  assign timeout_err = (TO_CYCLES < 0);
`endif

endmodule
